// File: rtl/wb_regfile_if.sv
// MEM/WB bus between the memory stage and the writeback stage: pipeline register
// outputs flowing into writeback, retired-write history flowing back to memory.
interface wb_regfile_if;
  logic        HREADY_D;
  logic [31:0] MEM_WB_pc;
  logic [31:0] MEM_WB_inst;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_data;

  logic        WB_fwd_vld_1;
  logic [4:0]  WB_fwd_rd_1;
  logic [31:0] WB_fwd_data_1;
  logic        WB_fwd_vld_2;
  logic [4:0]  WB_fwd_rd_2;
  logic [31:0] WB_fwd_data_2;

  modport master (
    output HREADY_D, MEM_WB_pc, MEM_WB_inst, MEM_WB_rd, MEM_WB_data,
    input  WB_fwd_vld_1, WB_fwd_rd_1, WB_fwd_data_1,
           WB_fwd_vld_2, WB_fwd_rd_2, WB_fwd_data_2
  );

  modport slave (
    input  HREADY_D, MEM_WB_pc, MEM_WB_inst, MEM_WB_rd, MEM_WB_data,
    output WB_fwd_vld_1, WB_fwd_rd_1, WB_fwd_data_1,
           WB_fwd_vld_2, WB_fwd_rd_2, WB_fwd_data_2
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32I writeback stage + 32x32 integer register file with bypassed read ports and
// a two-entry retired-write history. Define WB_INSTRET_EN to build the 64-bit instret counter.
module wb_regfile (
  input  logic         CLK,
  input  logic         RSTn,
  wb_regfile_if.slave  mem_wb,
  input  logic [4:0]   ID_rs1_addr,
  input  logic [4:0]   ID_rs2_addr,
  output logic [31:0]  ID_rs1_data,
  output logic [31:0]  ID_rs2_data,
  output logic [63:0]  WB_instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        wb_new;
  logic        wb_retire;
  logic        wb_we;
  logic        op_writes;
  logic [6:0]  opcode;

  logic [31:0] regs [1:31];

  logic        slot1_vld, slot2_vld;
  logic [4:0]  slot1_rd, slot2_rd;
  logic [31:0] slot1_data, slot2_data;

  // The PC travels with the instruction but nothing in writeback needs it.
  logic unused_pc;
  assign unused_pc = ^mem_wb.MEM_WB_pc;

  // wb_new marks that the MEM/WB register loaded at the last edge; a held entry
  // during a data-bus stall therefore retires exactly once.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) wb_new <= 1'b0;
    else       wb_new <= mem_wb.HREADY_D;
  end

  assign opcode = mem_wb.MEM_WB_inst[6:0];

  // NOTE: default assigned first so the decode stays purely combinational (no latch).
  always_comb begin
    op_writes = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_OPIMM, OP_OP, OP_SYSTEM: op_writes = 1'b1;
      default:                             op_writes = 1'b0;
    endcase
  end

  assign wb_retire = wb_new && (mem_wb.MEM_WB_inst != '0);
  assign wb_we     = wb_retire && (mem_wb.MEM_WB_rd != '0) && op_writes;

  // x0 has no storage; the array starts at x1.
  // NOTE: the register array is reset explicitly because reset must clear architectural state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[mem_wb.MEM_WB_rd] <= mem_wb.MEM_WB_data;
    end
  end

  // Write-through bypass gives decode zero-cycle visibility of the committing value.
  assign ID_rs1_data = (ID_rs1_addr == '0)                          ? '0 :
                       (wb_we && (ID_rs1_addr == mem_wb.MEM_WB_rd)) ? mem_wb.MEM_WB_data :
                                                                      regs[ID_rs1_addr];
  assign ID_rs2_data = (ID_rs2_addr == '0)                          ? '0 :
                       (wb_we && (ID_rs2_addr == mem_wb.MEM_WB_rd)) ? mem_wb.MEM_WB_data :
                                                                      regs[ID_rs2_addr];

  // Only register-writing retirements push; stores, branches and rd=0 leave history alone.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      slot1_vld  <= 1'b0;
      slot1_rd   <= '0;
      slot1_data <= '0;
      slot2_vld  <= 1'b0;
      slot2_rd   <= '0;
      slot2_data <= '0;
    end else if (wb_we) begin
      slot2_vld  <= slot1_vld;
      slot2_rd   <= slot1_rd;
      slot2_data <= slot1_data;
      slot1_vld  <= 1'b1;
      slot1_rd   <= mem_wb.MEM_WB_rd;
      slot1_data <= mem_wb.MEM_WB_data;
    end
  end

  assign mem_wb.WB_fwd_vld_1  = slot1_vld;
  assign mem_wb.WB_fwd_rd_1   = slot1_rd;
  assign mem_wb.WB_fwd_data_1 = slot1_data;
  assign mem_wb.WB_fwd_vld_2  = slot2_vld;
  assign mem_wb.WB_fwd_rd_2   = slot2_rd;
  assign mem_wb.WB_fwd_data_2 = slot2_data;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)          instret_q <= '0;
    else if (wb_retire) instret_q <= instret_q + 64'd1;
  end

  assign WB_instret = instret_q;
`else
  assign WB_instret = '0;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: bypass, x0, stall, history and async reset.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  wb_regfile_if mw ();

  wb_regfile dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .mem_wb      (mw.slave),
    .ID_rs1_addr (rs1_addr),
    .ID_rs2_addr (rs2_addr),
    .ID_rs1_data (rs1_data),
    .ID_rs2_data (rs2_data),
    .WB_instret  (instret)
  );

`ifdef WB_INSTRET_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [6:0] LUI = 7'b0110111, LOAD = 7'b0000011, OPIMM = 7'b0010011;
  localparam logic [6:0] OP  = 7'b0110011, STORE = 7'b0100011, BRANCH = 7'b1100011;

  function automatic logic [63:0] exp_cnt(input int n);
    return CNT_ON ? 64'(n) : 64'h0;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op);
    return {25'h00_00A5, op};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // HREADY_D high across an edge loads the next MEM/WB entry, which is then fresh.
  task automatic present(input logic [31:0] inst, input logic [4:0] rd, input logic [31:0] data);
    mw.HREADY_D = 1'b1;
    @(posedge CLK);
    #1;
    mw.MEM_WB_pc   = mw.MEM_WB_pc + 32'd4;
    mw.MEM_WB_inst = inst;
    mw.MEM_WB_rd   = rd;
    mw.MEM_WB_data = data;
  endtask

  task automatic stall();
    mw.HREADY_D = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic fwd(input string tag, input logic [4:0] rd1, input logic [31:0] d1,
                     input logic [4:0] rd2, input logic [31:0] d2);
    check({tag, "_vld1"},  64'(mw.WB_fwd_vld_1),  64'd1);
    check({tag, "_rd1"},   64'(mw.WB_fwd_rd_1),   64'(rd1));
    check({tag, "_data1"}, 64'(mw.WB_fwd_data_1), 64'(d1));
    check({tag, "_vld2"},  64'(mw.WB_fwd_vld_2),  64'd1);
    check({tag, "_rd2"},   64'(mw.WB_fwd_rd_2),   64'(rd2));
    check({tag, "_data2"}, 64'(mw.WB_fwd_data_2), 64'(d2));
  endtask

  initial begin
    RSTn           = 1'b0;
    mw.HREADY_D    = 1'b0;
    mw.MEM_WB_pc   = 32'h0000_1000;
    mw.MEM_WB_inst = mk(OPIMM);
    mw.MEM_WB_rd   = 5'd6;
    mw.MEM_WB_data = 32'h66;
    rs1_addr       = 5'd6;
    rs2_addr       = 5'd5;

    #12;
    check("rst_rs1",     64'(rs1_data), 64'h0);
    check("rst_rs2",     64'(rs2_data), 64'h0);
    check("rst_vld1",    64'(mw.WB_fwd_vld_1), 64'h0);
    check("rst_vld2",    64'(mw.WB_fwd_vld_2), 64'h0);
    check("rst_data1",   64'(mw.WB_fwd_data_1), 64'h0);
    check("rst_instret", instret, 64'h0);
    RSTn = 1'b1;

    // Entry held at reset release is not fresh: no bypass of x6.
    @(negedge CLK);
    check("first_entry_not_retired", 64'(rs1_data), 64'h0);

    // ADDI x5 = 0x1234: bypass now, registers and history next cycle.
    rs1_addr = 5'd5;
    present(mk(OPIMM), 5'd5, 32'h0000_1234);
    @(negedge CLK);
    check("addi_bypass",   64'(rs1_data), 64'h1234);
    check("addi_vld1_pre", 64'(mw.WB_fwd_vld_1), 64'h0);
    present(32'h0, 5'd0, 32'h0);
    @(negedge CLK);
    check("addi_reg",     64'(rs1_data), 64'h1234);
    check("addi_vld1",    64'(mw.WB_fwd_vld_1), 64'h1);
    check("addi_rd1",     64'(mw.WB_fwd_rd_1), 64'd5);
    check("addi_vld2",    64'(mw.WB_fwd_vld_2), 64'h0);
    check("addi_instret", instret, exp_cnt(1));

    // Both ports bypass x7 in the same cycle.
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    present(mk(OP), 5'd7, 32'hDEAD_BEEF);
    @(negedge CLK);
    check("dual_bypass_rs1", 64'(rs1_data), 64'hDEAD_BEEF);
    check("dual_bypass_rs2", 64'(rs2_data), 64'hDEAD_BEEF);

    // Write to x0: retires but never stores, bypasses or pushes.
    rs1_addr = 5'd0;
    present(mk(OPIMM), 5'd0, 32'hFFFF_FFFF);
    @(negedge CLK);
    check("x0_read",   64'(rs1_data), 64'h0);
    check("x7_stored", 64'(rs2_data), 64'hDEAD_BEEF);
    present(32'h0, 5'd0, 32'h0);
    @(negedge CLK);
    check("x0_read_after", 64'(rs1_data), 64'h0);
    fwd("x0_hist", 5'd7, 32'hDEAD_BEEF, 5'd5, 32'h1234);
    check("x0_instret", instret, exp_cnt(3));

    // LW x9 held on MEM/WB through a three-cycle stall commits exactly once.
    rs1_addr = 5'd9;
    present(mk(LOAD), 5'd9, 32'hA5);
    @(negedge CLK);
    check("lw_bypass", 64'(rs1_data), 64'hA5);
    stall();
    @(negedge CLK);
    fwd("lw_push", 5'd9, 32'hA5, 5'd7, 32'hDEAD_BEEF);
    check("lw_instret", instret, exp_cnt(4));
    stall();
    stall();
    @(negedge CLK);
    check("stall_reg",     64'(rs1_data), 64'hA5);
    fwd("stall_hold", 5'd9, 32'hA5, 5'd7, 32'hDEAD_BEEF);
    check("stall_instret", instret, exp_cnt(4));

    // x3, x4, then a store and a branch that must neither write nor push.
    present(mk(OP), 5'd3, 32'h11);
    present(mk(LUI), 5'd4, 32'h22);
    rs1_addr = 5'd5;
    present(mk(STORE), 5'd5, 32'h99);
    @(negedge CLK);
    check("store_no_bypass", 64'(rs1_data), 64'h1234);
    fwd("two_writes", 5'd4, 32'h22, 5'd3, 32'h11);
    rs1_addr = 5'd6;
    present(mk(BRANCH), 5'd6, 32'h77);
    @(negedge CLK);
    check("branch_no_bypass", 64'(rs1_data), 64'h0);
    fwd("store_no_push", 5'd4, 32'h22, 5'd3, 32'h11);
    check("store_instret", instret, exp_cnt(7));

    // Rewrite x4: same rd lands in both slots, newer in slot1.
    rs1_addr = 5'd4;
    rs2_addr = 5'd3;
    present(mk(OP), 5'd4, 32'h33);
    @(negedge CLK);
    check("rewrite_bypass", 64'(rs1_data), 64'h33);
    check("x3_stored",      64'(rs2_data), 64'h11);
    stall();
    @(negedge CLK);
    fwd("same_rd", 5'd4, 32'h33, 5'd4, 32'h22);
    check("same_rd_instret", instret, exp_cnt(9));

    // Asynchronous reset mid-stall clears everything without a clock edge.
    stall();
    #2;
    RSTn = 1'b0;
    #1;
    check("async_rs1",     64'(rs1_data), 64'h0);
    check("async_rs2",     64'(rs2_data), 64'h0);
    check("async_vld1",    64'(mw.WB_fwd_vld_1), 64'h0);
    check("async_vld2",    64'(mw.WB_fwd_vld_2), 64'h0);
    check("async_rd1",     64'(mw.WB_fwd_rd_1), 64'h0);
    check("async_instret", instret, 64'h0);
    #5;
    RSTn = 1'b1;
    @(negedge CLK);
    check("post_rst_rs1", 64'(rs1_data), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
